// File: rtl/vga_fb_ctrl_if.sv
// Write/clear port of the VGA framebuffer controller.
//   wr_valid/wr_ready : write handshake, transfer when both high on a clk edge
//   wr_x/wr_y/wr_pixel: pixel coordinate and colour of the write
//   clear_req         : start a full-buffer fill with clear_color
//   clear_busy        : fill in progress, write port stalled
// XW/YW may be wider than the framebuffer needs, so that a caller can pass
// unclamped coordinates and let the controller drop the off-screen ones.
interface vga_fb_ctrl_if #(
    parameter int unsigned XW  = 10,
    parameter int unsigned YW  = 9,
    parameter int unsigned BPP = 3
);
    logic           wr_valid;
    logic           wr_ready;
    logic [XW-1:0]  wr_x;
    logic [YW-1:0]  wr_y;
    logic [BPP-1:0] wr_pixel;
    logic           clear_req;
    logic [BPP-1:0] clear_color;
    logic           clear_busy;

    // Drawing logic side.
    modport master (
        output wr_valid, wr_x, wr_y, wr_pixel, clear_req, clear_color,
        input  wr_ready, clear_busy
    );

    // Framebuffer controller side.
    modport slave (
        input  wr_valid, wr_x, wr_y, wr_pixel, clear_req, clear_color,
        output wr_ready, clear_busy
    );
endinterface

// File: rtl/vga_fb_ctrl.sv
// VGA timing generator with an on-chip linear framebuffer.
//   clk, srst   : system clock, synchronous active-high reset
//   bus (slave) : pixel write handshake and clear-engine control
//   hsync/vsync : sync pulses, active level set by HSYNC_POL/VSYNC_POL
//   visible     : RGB carries active video
//   frame_start : one pixel-tick pulse when pixel (0,0) is on the outputs
//   RGB         : pixel colour, 0 outside the visible area
// The pixel rate is a clock enable (one clk in CLK_DIV). The display path is
// counters -> synchronous RAM read -> output registers, so every output lags
// its counter position by two pixel ticks.
module vga_fb_ctrl #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned BPP       = 3,
    parameter int unsigned CLK_DIV   = 1,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0
) (
    input  logic           clk,
    input  logic           srst,
    vga_fb_ctrl_if.slave   bus,
    output logic           hsync,
    output logic           vsync,
    output logic           visible,
    output logic           frame_start,
    output logic [BPP-1:0] RGB
);
    localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned N  = H_ACTIVE * V_ACTIVE;
    localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned HW = $clog2(HT);
    localparam int unsigned VW = $clog2(VT);
    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [0:0] {StIdle, StClear} state_t;

    // Pixel clock enable.
    logic [DW-1:0] div_q;
    logic          pix_en;

    assign pix_en = (div_q == '0);

    always_ff @(posedge clk) begin
        if (srst)                            div_q <= '0;
        else if (32'(div_q) == CLK_DIV - 1) div_q <= '0;
        else                                 div_q <= div_q + 1'b1;
    end

    // Stage 0: raster counters and read address.
    logic [HW-1:0] hcnt_q;
    logic [VW-1:0] vcnt_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else if (pix_en) begin
            if (32'(hcnt_q) == HT - 1) begin
                hcnt_q <= '0;
                vcnt_q <= (32'(vcnt_q) == VT - 1) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_q <= hcnt_q + 1'b1;
            end
        end
    end

    logic          s0_vis, s0_hs, s0_vs, s0_fs;
    logic [AW-1:0] rd_addr;

    always_comb begin
        s0_vis  = (32'(hcnt_q) < H_ACTIVE) && (32'(vcnt_q) < V_ACTIVE);
        s0_hs   = (32'(hcnt_q) >= H_ACTIVE + H_FP) && (32'(hcnt_q) < H_ACTIVE + H_FP + H_SYNC);
        s0_vs   = (32'(vcnt_q) >= V_ACTIVE + V_FP) && (32'(vcnt_q) < V_ACTIVE + V_FP + V_SYNC);
        s0_fs   = (hcnt_q == '0) && (vcnt_q == '0);
        // Blanking positions would index past the buffer; park them on 0.
        rd_addr = s0_vis ? AW'(32'(vcnt_q) * H_ACTIVE + 32'(hcnt_q)) : '0;
    end

    // Clear engine.
    state_t         state_q, state_d;
    logic [AW-1:0]  clr_addr_q, clr_addr_d;
    logic [BPP-1:0] clr_color_q, clr_color_d;
    logic           clear_busy;

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        clr_color_d = clr_color_q;
        unique case (state_q)
            StIdle: begin
                if (bus.clear_req) begin
                    state_d     = StClear;
                    clr_addr_d  = '0;
                    clr_color_d = bus.clear_color;
                end
            end
            StClear: begin
                if (32'(clr_addr_q) == N - 1) state_d    = StIdle;
                else                          clr_addr_d = clr_addr_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // Reset doubles as a clear to colour 0 so the buffer never shows garbage.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= StClear;
            clr_addr_q  <= '0;
            clr_color_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            clr_color_q <= clr_color_d;
        end
    end

    assign clear_busy     = (state_q == StClear);
    assign bus.clear_busy = clear_busy;
    assign bus.wr_ready   = !clear_busy;

    // Write port: accepted writes are registered and land one clk later.
    logic           wr_in_range;
    logic           wr_pend_q;
    logic [AW-1:0]  wr_addr_q;
    logic [BPP-1:0] wr_data_q;

    assign wr_in_range = (32'(bus.wr_x) < H_ACTIVE) && (32'(bus.wr_y) < V_ACTIVE);

    always_ff @(posedge clk) begin
        if (srst) wr_pend_q <= 1'b0;
        else      wr_pend_q <= bus.wr_valid && !clear_busy && wr_in_range;
    end

    always_ff @(posedge clk) begin
        wr_addr_q <= AW'(32'(bus.wr_y) * H_ACTIVE + 32'(bus.wr_x));
        wr_data_q <= bus.wr_pixel;
    end

    // A write accepted on the cycle a clear starts lands while the clear owns
    // the RAM port; dropping it is safe because the clear rewrites every pixel.
    logic           mem_we;
    logic [AW-1:0]  mem_waddr;
    logic [BPP-1:0] mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr_q;
        mem_wdata = wr_data_q;
        if (!srst) begin
            if (clear_busy) begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr_q;
                mem_wdata = clr_color_q;
            end else if (wr_pend_q) begin
                mem_we = 1'b1;
            end
        end
    end

    // Stage 1: RAM read (old data on a same-address write) plus delayed flags.
    logic [BPP-1:0] mem [N];
    logic [BPP-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (pix_en) rd_data_q <= mem[rd_addr];
    end

    logic s1_vis_q, s1_hs_q, s1_vs_q, s1_fs_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            s1_vis_q <= 1'b0;
            s1_hs_q  <= 1'b0;
            s1_vs_q  <= 1'b0;
            s1_fs_q  <= 1'b0;
        end else if (pix_en) begin
            s1_vis_q <= s0_vis;
            s1_hs_q  <= s0_hs;
            s1_vs_q  <= s0_vs;
            s1_fs_q  <= s0_fs;
        end
    end

    // Stage 2: registered pin outputs.
    always_ff @(posedge clk) begin
        if (srst) begin
            RGB         <= '0;
            visible     <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= !HSYNC_POL;
            vsync       <= !VSYNC_POL;
        end else if (pix_en) begin
            RGB         <= s1_vis_q ? rd_data_q : '0;
            visible     <= s1_vis_q;
            frame_start <= s1_fs_q;
            hsync       <= s1_hs_q ? HSYNC_POL : !HSYNC_POL;
            vsync       <= s1_vs_q ? VSYNC_POL : !VSYNC_POL;
        end
    end
endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Self-checking bench for vga_fb_ctrl on a tiny 8x4 raster.
// Expected outputs come from the raster rules: time since reset release gives
// the pixel-tick count, the tick count gives the raster position two ticks
// back, and a pixel array holds what the framebuffer should contain.
module tb_vga_fb_ctrl;
    localparam int H_ACTIVE  = 8;
    localparam int H_FP      = 2;
    localparam int H_SYNC    = 3;
    localparam int H_BP      = 1;
    localparam int V_ACTIVE  = 4;
    localparam int V_FP      = 1;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 1;
    localparam int BPP       = 3;
    localparam int CLK_DIV   = 2;
    localparam int HT        = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT        = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int N         = H_ACTIVE * V_ACTIVE;
    localparam int FRAME     = HT * VT;
    localparam int FRAME_CLK = FRAME * CLK_DIV;
    localparam int NEVER     = 32'h3fff_ffff;

    logic           clk = 1'b0;
    logic           srst;
    logic           hsync, vsync, visible, frame_start;
    logic [BPP-1:0] RGB;

    // One extra coordinate bit so off-screen writes can be expressed.
    vga_fb_ctrl_if #(.XW(4), .YW(3), .BPP(BPP)) bus ();

    vga_fb_ctrl #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .BPP (BPP), .CLK_DIV (CLK_DIV), .HSYNC_POL (1'b0), .VSYNC_POL (1'b0)
    ) dut (
        .clk         (clk),
        .srst        (srst),
        .bus         (bus),
        .hsync       (hsync),
        .vsync       (vsync),
        .visible     (visible),
        .frame_start (frame_start),
        .RGB         (RGB)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int k        = 0;      // clk edges since the last reset edge
    int last_mod = NEVER;  // last edge that may have written the framebuffer
    int fb [N];

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, exp, k);
        end
    endtask

    task automatic monitor();
        int n, p, q, h, v;
        bit vis;
        n = (k + 1) / CLK_DIV;
        if (k == 0 || n < 2) begin
            check_eq("rst_vis", visible, 0);
            check_eq("rst_hs", hsync, 1);
            check_eq("rst_vs", vsync, 1);
            check_eq("rst_fs", frame_start, 0);
            check_eq("rst_rgb", RGB, 0);
            return;
        end
        p   = n - 2;
        q   = p % FRAME;
        h   = q % HT;
        v   = q / HT;
        vis = (h < H_ACTIVE) && (v < V_ACTIVE);
        check_eq($sformatf("vis@%0d,%0d", h, v), visible, vis);
        check_eq($sformatf("hs@%0d", h), hsync,
                 (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? 0 : 1);
        check_eq($sformatf("vs@%0d", v), vsync,
                 (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? 0 : 1);
        check_eq($sformatf("fs@%0d,%0d", h, v), frame_start, (q == 0) ? 1 : 0);
        // Position p was read from RAM on edge CLK_DIV*p+1.
        if (!vis)
            check_eq($sformatf("blank_rgb@%0d,%0d", h, v), RGB, 0);
        else if (CLK_DIV * p + 1 > last_mod)
            check_eq($sformatf("rgb@%0d,%0d", h, v), RGB, fb[v * H_ACTIVE + h]);
    endtask

    task automatic step();
        logic rst_now;
        rst_now = srst;
        @(posedge clk);
        #1;
        if (rst_now) begin
            k        = 0;
            last_mod = N;
            foreach (fb[i]) fb[i] = 0;
        end else begin
            k++;
        end
        monitor();
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic fill_model(input int color);
        foreach (fb[i]) fb[i] = color;
        last_mod = NEVER;
    endtask

    // Counts busy cycles from the current sample; inputs held asserted during
    // the clear are released as soon as busy falls.
    task automatic wait_clear(input string tag);
        int cnt;
        cnt = 0;
        while (bus.clear_busy && cnt < 100) begin
            check_eq({tag, "_rdy"}, bus.wr_ready, 0);
            cnt++;
            step();
        end
        bus.wr_valid  = 1'b0;
        bus.clear_req = 1'b0;
        check_eq({tag, "_len"}, cnt, N);
        check_eq({tag, "_rdy_after"}, bus.wr_ready, 1);
        last_mod = k;
    endtask

    task automatic do_write(input int x, input int y, input int pix);
        int  waited;
        logic rdy;
        waited       = 0;
        bus.wr_valid = 1'b1;
        bus.wr_x     = 4'(x);
        bus.wr_y     = 3'(y);
        bus.wr_pixel = 3'(pix);
        do begin
            rdy = bus.wr_ready;
            step();
            waited++;
        end while (!rdy && waited < 100);
        bus.wr_valid = 1'b0;
        check_eq($sformatf("wr_lat(%0d,%0d)", x, y), waited, 1);
        if (x < H_ACTIVE && y < V_ACTIVE) fb[y * H_ACTIVE + x] = pix;
        last_mod = k + 1;
    endtask

    task automatic find_fs_rise(output int kk);
        int   guard;
        logic prev;
        guard = 0;
        kk    = -1;
        prev  = frame_start;
        while (guard < 2 * FRAME_CLK) begin
            step();
            guard++;
            if (frame_start && !prev) begin
                kk = k;
                break;
            end
            prev = frame_start;
        end
        check_eq("fs_found", (kk >= 0) ? 1 : 0, 1);
    endtask

    initial begin
        int k0, k1, guard;
        srst            = 1'b1;
        bus.wr_valid    = 1'b0;
        bus.wr_x        = '0;
        bus.wr_y        = '0;
        bus.wr_pixel    = '0;
        bus.clear_req   = 1'b0;
        bus.clear_color = '0;
        run(3);
        check_eq("rst_busy", bus.clear_busy, 1);
        srst = 1'b0;

        // Reset release: clear to 0, then a black frame.
        wait_clear("rst_clr");
        run(FRAME_CLK + 20);

        // Free-run timing and frame_start period.
        find_fs_rise(k0);
        find_fs_rise(k1);
        check_eq("fs_period", k1 - k0, FRAME_CLK);

        // Two single-pixel writes.
        do_write(3, 1, 5);
        do_write(7, 3, 2);
        run(2 * FRAME_CLK);

        // Clear during active video; write and second clear_req ignored.
        guard = 0;
        while (!visible && guard < FRAME_CLK) begin
            step();
            guard++;
        end
        check_eq("in_active", visible, 1);
        fill_model(6);
        bus.clear_req   = 1'b1;
        bus.clear_color = 3'd6;
        step();
        bus.clear_color = 3'd3;
        bus.wr_valid    = 1'b1;
        bus.wr_x        = 4'd0;
        bus.wr_y        = 3'd0;
        bus.wr_pixel    = 3'd7;
        wait_clear("clr6");
        step();
        check_eq("clr6_no_restart", bus.clear_busy, 0);
        run(2 * FRAME_CLK);

        // Write and clear_req in the same idle cycle: clear wins.
        fill_model(1);
        bus.wr_valid    = 1'b1;
        bus.wr_x        = 4'd1;
        bus.wr_y        = 3'd1;
        bus.wr_pixel    = 3'd4;
        bus.clear_req   = 1'b1;
        bus.clear_color = 3'd1;
        check_eq("same_rdy", bus.wr_ready, 1);
        step();
        bus.wr_valid  = 1'b0;
        bus.clear_req = 1'b0;
        wait_clear("same");
        run(2 * FRAME_CLK);

        // Off-screen writes are accepted and dropped.
        do_write(8, 0, 7);
        do_write(2, 4, 7);
        run(2 * FRAME_CLK);

        // Random writes, some off-screen, with random gaps.
        for (int i = 0; i < 24; i++) begin
            do_write(int'($urandom_range(0, 9)), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 7)));
            run(int'($urandom_range(0, 3)));
        end
        run(2 * FRAME_CLK);

        // Reset at clear address 10 restarts the clear with colour 0.
        fill_model(5);
        bus.clear_req   = 1'b1;
        bus.clear_color = 3'd5;
        step();
        bus.clear_req = 1'b0;
        run(10);
        srst = 1'b1;
        step();
        srst = 1'b0;
        wait_clear("mid_rst");
        run(2 * FRAME_CLK);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
